// File: rtl/lfsr_pair_gen.sv
// Operand-pair generator: two 4-bit Fibonacci LFSRs stepped in lockstep,
// presented over a valid/ready handshake with an IDLE/RUN/DONE run controller.
module lfsr_pair_gen #(
    parameter logic [3:0]  TAPS      = 4'b1100,
    parameter int unsigned MAX_PAIRS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_we,
    input  logic [3:0] seed_a,
    input  logic [3:0] seed_b,
    input  logic       start,
    input  logic       stop,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic       done,
    output logic [7:0] gen_cnt,
    output logic       seed_fix
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic       LIMITED  = (MAX_PAIRS != 0);
    localparam logic [7:0] MAX_CNT  = MAX_PAIRS[7:0];
    localparam logic [3:0] RST_A    = 4'b0001;
    localparam logic [3:0] RST_B    = 4'b1000;
    localparam logic [3:0] ZERO_SUB = 4'b0001;

    // A non-default tap mask could map 4'b1000 onto zero; the guard keeps
    // the lock-up state unreachable for any TAPS value.
    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        logic [3:0] n;
        n = {s[2:0], ^(s & TAPS)};
        return (n == 4'b0000) ? ZERO_SUB : n;
    endfunction

    function automatic logic [3:0] seed_clean(input logic [3:0] s);
        return (s == 4'b0000) ? ZERO_SUB : s;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fix_q, fix_d;

    logic       handshake;
    logic [7:0] cnt_inc;

    assign handshake = (state_q == S_RUN) && out_ready;
    assign cnt_inc   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    // NOTE: every variable gets its hold value before the case statement so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        fix_d   = fix_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (seed_we) begin
                    a_d = seed_clean(seed_a);
                    b_d = seed_clean(seed_b);
                    if ((seed_a == 4'b0000) || (seed_b == 4'b0000)) begin
                        fix_d = 1'b1;
                    end
                end
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                end
            end

            S_RUN: begin
                if (handshake) begin
                    a_d   = lfsr_step(a_q);
                    b_d   = lfsr_step(b_q);
                    cnt_d = cnt_inc;
                    // Completion outranks a coincident stop.
                    if (LIMITED && (cnt_inc == MAX_CNT)) begin
                        state_d = S_DONE;
                    end else if (stop) begin
                        state_d = S_IDLE;
                    end
                end else if (stop) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= RST_A;
            b_q     <= RST_B;
            cnt_q   <= 8'd0;
            fix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            fix_q   <= fix_d;
        end
    end

    assign out_valid = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign gen_cnt   = cnt_q;
    assign seed_fix  = fix_q;

endmodule

// File: tb/tb_lfsr_pair_gen.sv
// Directed bench for lfsr_pair_gen: a default instance (16 pairs per run)
// and an unlimited instance (MAX_PAIRS=0) for the counter saturation case.
module tb_lfsr_pair_gen;

    logic       clk = 1'b0;
    logic       rst, seed_we, start, stop, out_ready;
    logic [3:0] seed_a, seed_b;
    logic       out_valid, done, seed_fix;
    logic [3:0] out_a, out_b;
    logic [7:0] gen_cnt;

    logic       u_start, u_ready;
    logic       u_valid, u_done, u_fix;
    logic [3:0] u_a, u_b;
    logic [7:0] u_cnt;

    int checks = 0;
    int errors = 0;

    // Hand-derived sequence from state 0001 with taps 1100.
    logic [3:0] seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                             4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};

    always #5 clk = ~clk;

    lfsr_pair_gen dut (
        .clk(clk), .rst(rst), .seed_we(seed_we), .seed_a(seed_a), .seed_b(seed_b),
        .start(start), .stop(stop), .out_ready(out_ready), .out_valid(out_valid),
        .out_a(out_a), .out_b(out_b), .done(done), .gen_cnt(gen_cnt), .seed_fix(seed_fix)
    );

    lfsr_pair_gen #(.TAPS(4'b1100), .MAX_PAIRS(0)) dut_u (
        .clk(clk), .rst(rst), .seed_we(1'b0), .seed_a(4'd0), .seed_b(4'd0),
        .start(u_start), .stop(1'b0), .out_ready(u_ready), .out_valid(u_valid),
        .out_a(u_a), .out_b(u_b), .done(u_done), .gen_cnt(u_cnt), .seed_fix(u_fix)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; seed_we = 1'b0; seed_a = 4'd0; seed_b = 4'd0;
        start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        u_start = 1'b0; u_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", {7'd0, out_valid}, 8'd0);
        check("rst_done",  {7'd0, done}, 8'd0);
        check("rst_cnt",   gen_cnt, 8'd0);
        check("rst_a",     {4'd0, out_a}, 8'd1);
        check("rst_b",     {4'd0, out_b}, 8'd8);
        check("rst_fix",   {7'd0, seed_fix}, 8'd0);

        // Full run at out_ready=1: 16 pairs then DONE
        start = 1'b1; tick(); start = 1'b0;
        check("run_valid", {7'd0, out_valid}, 8'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("seq_a",   {4'd0, out_a}, {4'd0, seq[i % 15]});
            check("seq_b",   {4'd0, out_b}, {4'd0, seq[(i + 14) % 15]});
            check("seq_cnt", gen_cnt, 8'(i));
            tick();
        end
        out_ready = 1'b0;
        check("done_flag",  {7'd0, done}, 8'd1);
        check("done_valid", {7'd0, out_valid}, 8'd0);
        check("done_cnt",   gen_cnt, 8'd16);
        check("done_a",     {4'd0, out_a}, 8'd2);
        check("done_b",     {4'd0, out_b}, 8'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_in_done", {7'd0, done}, 8'd1);

        // Restart from DONE continues the LFSRs; stall 5 cycles
        start = 1'b1; tick(); start = 1'b0;
        check("restart_done",  {7'd0, done}, 8'd0);
        check("restart_cnt",   gen_cnt, 8'd0);
        check("restart_a",     {4'd0, out_a}, 8'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {7'd0, out_valid}, 8'd1);
            check("stall_a",     {4'd0, out_a}, 8'd2);
            check("stall_b",     {4'd0, out_b}, 8'd1);
            check("stall_cnt",   gen_cnt, 8'd0);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("unstall_a",   {4'd0, out_a}, 8'd4);
        check("unstall_b",   {4'd0, out_b}, 8'd2);
        check("unstall_cnt", gen_cnt, 8'd1);

        // Stop without handshake at gen_cnt=3
        out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
        check("pre_stop_cnt", gen_cnt, 8'd3);
        check("pre_stop_a",   {4'd0, out_a}, 8'd3);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_nohs_valid", {7'd0, out_valid}, 8'd0);
        check("stop_nohs_a",     {4'd0, out_a}, 8'd3);
        check("stop_nohs_b",     {4'd0, out_b}, 8'd9);
        check("stop_nohs_cnt",   gen_cnt, 8'd3);

        // Stop with handshake at gen_cnt=3
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b1; tick(); tick(); tick();
        check("pre_stop2_cnt", gen_cnt, 8'd3);
        check("pre_stop2_a",   {4'd0, out_a}, 8'd10);
        stop = 1'b1; tick(); stop = 1'b0; out_ready = 1'b0;
        check("stop_hs_valid", {7'd0, out_valid}, 8'd0);
        check("stop_hs_cnt",   gen_cnt, 8'd4);
        check("stop_hs_a",     {4'd0, out_a}, 8'd5);
        check("stop_hs_b",     {4'd0, out_b}, 8'd10);

        // Nonzero seed load in IDLE, then mid-run reset at gen_cnt=7
        seed_we = 1'b1; seed_a = 4'd6; seed_b = 4'd3; tick(); seed_we = 1'b0;
        check("seed_idle_a",   {4'd0, out_a}, 8'd6);
        check("seed_idle_fix", {7'd0, seed_fix}, 8'd0);
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b1;
        repeat (7) tick();
        check("mid_cnt", gen_cnt, 8'd7);
        check("mid_a",   {4'd0, out_a}, 8'd14);
        check("mid_b",   {4'd0, out_b}, 8'd15);
        rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
        check("mrst_valid", {7'd0, out_valid}, 8'd0);
        check("mrst_done",  {7'd0, done}, 8'd0);
        check("mrst_cnt",   gen_cnt, 8'd0);
        check("mrst_a",     {4'd0, out_a}, 8'd1);
        check("mrst_b",     {4'd0, out_b}, 8'd8);

        // Zero seed with start in the same cycle
        seed_we = 1'b1; seed_a = 4'd0; seed_b = 4'd6; start = 1'b1; tick();
        seed_we = 1'b0; start = 1'b0;
        check("zseed_valid", {7'd0, out_valid}, 8'd1);
        check("zseed_a",     {4'd0, out_a}, 8'd1);
        check("zseed_b",     {4'd0, out_b}, 8'd6);
        check("zseed_fix",   {7'd0, seed_fix}, 8'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("zseed_step_a", {4'd0, out_a}, 8'd2);
        check("zseed_step_b", {4'd0, out_b}, 8'd13);
        seed_we = 1'b1; seed_a = 4'd5; seed_b = 4'd5; start = 1'b1; tick();
        seed_we = 1'b0; start = 1'b0;
        check("run_seed_ign_a", {4'd0, out_a}, 8'd2);
        check("run_start_ign",  gen_cnt, 8'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("fix_sticky", {7'd0, seed_fix}, 8'd1);
        seed_we = 1'b1; seed_a = 4'd15; seed_b = 4'd0; tick(); seed_we = 1'b0;
        check("zseed_b_load", {4'd0, out_b}, 8'd1);
        check("seed_a_load",  {4'd0, out_a}, 8'd15);
        check("seed_no_run",  {7'd0, out_valid}, 8'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("fix_clear", {7'd0, seed_fix}, 8'd0);

        // Completion coinciding with stop: DONE wins
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b1;
        repeat (15) tick();
        check("pre_last_cnt", gen_cnt, 8'd15);
        stop = 1'b1; tick(); stop = 1'b0; out_ready = 1'b0;
        check("prio_done", {7'd0, done}, 8'd1);
        check("prio_cnt",  gen_cnt, 8'd16);

        // Unlimited instance: gen_cnt saturates, run never completes
        u_start = 1'b1; tick(); u_start = 1'b0;
        u_ready = 1'b1;
        repeat (255) tick();
        check("sat_cnt_255", u_cnt, 8'd255);
        repeat (45) tick();
        u_ready = 1'b0;
        check("sat_cnt_hold", u_cnt, 8'd255);
        check("sat_valid",    {7'd0, u_valid}, 8'd1);
        check("sat_done",     {7'd0, u_done}, 8'd0);
        check("sat_a",        {4'd0, u_a}, 8'd1);
        check("sat_b",        {4'd0, u_b}, 8'd8);
        check("sat_fix",      {7'd0, u_fix}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_pair_gen.md
LFSR_PAIR_GEN -- requirements
Module: lfsr_pair_gen

Interface
REQ-001 Parameter: TAPS, default 4'b1100, feedback tap mask; feedback bit = XOR of state bits where TAPS=1.
REQ-002 Parameter: MAX_PAIRS, default 16, operand pairs per run (1..255); 0 = unlimited.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: seed_we  input  1  load seed_a/seed_b (honoured in IDLE/DONE only).
REQ-006 Port: seed_a  input  4  seed for LFSR A.
REQ-007 Port: seed_b  input  4  seed for LFSR B.
REQ-008 Port: start  input  1  begin a run (honoured in IDLE/DONE only).
REQ-009 Port: stop  input  1  abort current run (honoured in RUN only).
REQ-010 Port: out_ready  input  1  downstream (adder/parity stage) accepts current pair.
REQ-011 Port: out_valid  output  1  out_a/out_b hold a valid pair.
REQ-012 Port: out_a  output  4  operand A = LFSR A state.
REQ-013 Port: out_b  output  4  operand B = LFSR B state.
REQ-014 Port: done  output  1  run completed MAX_PAIRS handshakes.
REQ-015 Port: gen_cnt  output  8  handshakes completed in current run.
REQ-016 Port: seed_fix  output  1  sticky: a zero seed was replaced.

Function
REQ-017 LFSR step SHALL be next = {S[2:0], ^(S & TAPS)}; A and B step together, only on a handshake (out_valid & out_ready).
REQ-018 Default TAPS SHALL give period 15 over nonzero states; all-zero state SHALL never be entered.
REQ-019 Seed load of 4'b0000 (either LFSR) SHALL load 4'b0001 instead and set seed_fix; seed_fix clears only on rst.
REQ-020 FSM states SHALL be IDLE, RUN, DONE; out_valid=1 only in RUN.
REQ-021 IDLE: start -> RUN next cycle, gen_cnt cleared to 0.
REQ-022 RUN: on handshake, gen_cnt+1 and LFSRs step; if MAX_PAIRS!=0 and new gen_cnt==MAX_PAIRS -> DONE.
REQ-023 RUN: out_valid asserted and out_a/out_b SHALL stay stable until handshake (no retraction, no change while out_ready=0).
REQ-024 RUN: stop without handshake -> IDLE, pair not consumed, LFSRs unchanged; stop with handshake same cycle -> handshake completes (count, step), then IDLE.
REQ-025 Completion and stop in same cycle: DONE takes priority.
REQ-026 DONE: done=1, out_valid=0; start -> RUN, done=0, gen_cnt=0, LFSRs continue from current state.
REQ-027 seed_we and start in same cycle (IDLE/DONE): seed loaded and run starts; first pair presented = loaded seed.
REQ-028 seed_we/start in RUN, stop in IDLE/DONE: ignored.
REQ-029 MAX_PAIRS=0: gen_cnt saturates at 255, never reaches DONE.
REQ-030 Latency: pair on out_a/out_b is registered state; next pair visible cycle after handshake.

Reset
REQ-031 rst SHALL force IDLE, A=4'b0001, B=4'b1000, out_valid=0, done=0, gen_cnt=0, seed_fix=0.
REQ-032 rst has priority over all inputs, including mid-run; in-flight pair discarded, no handshake counted that cycle.

Verification
REQ-033 rst, start, out_ready=1: out_a = 1,2,4,9,3,...; out_b = 8,1,2,4,9,...; done after 16 handshakes, gen_cnt=16.
REQ-034 RUN, out_ready=0 for 5 cycles: out_valid=1, out_a/out_b constant, gen_cnt constant; ready=1 -> one step.
REQ-035 IDLE, seed_we with seed_a=0, seed_b=4'b0110, start same cycle: first pair (1,6), seed_fix=1 until rst.
REQ-036 RUN gen_cnt=3, stop with out_ready=0 -> IDLE, pair unchanged; stop with out_ready=1 -> gen_cnt=4, then IDLE.
REQ-037 rst asserted mid-run at gen_cnt=7: next cycle all outputs at reset values, out_a=1, out_b=8.
REQ-038 Sweep 15 handshakes from A=0001: A returns to 0001, never 0000; MAX_PAIRS=0 run: gen_cnt holds 255.
